// File: rtl/cmt_ctrl_mw_pkg.sv
// Shared types and constants for the multi-lane commit controller.
// Holds the FSM encoding, lane event types, interrupt cause codes and width helpers.
package cmt_ctrl_mw_pkg;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_GAP,
        ST_WFI_REQ,
        ST_SLEEP,
        ST_WAKE
    } cmt_state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_EXCP,
        EV_MRET,
        EV_WFI,
        EV_BJP
    } cmt_event_e;

    // Width of the retire count (LANE_CNT_W) and of a lane index.
    function automatic int lane_cnt_w(input int nlane);
        return $clog2(nlane + 1);
    endfunction

    function automatic int lane_idx_w(input int nlane);
        return (nlane > 1) ? $clog2(nlane) : 1;
    endfunction

    // Highest-priority enabled interrupt: MEI > MSI > MTI.
    function automatic logic [3:0] irq_code(input logic ext_en, input logic sft_en);
        if (ext_en)      return IRQ_MEI;
        else if (sft_en) return IRQ_MSI;
        else             return IRQ_MTI;
    endfunction

endpackage

// File: rtl/cmt_lane_sel.sv
// Finds the oldest lane in the contiguous valid group that carries a commit event.
// Returns its index, the event kind and how many lanes retire ahead of or with it.
module cmt_lane_sel
    import cmt_ctrl_mw_pkg::*;
#(
    parameter  int NLANE = 2,
    localparam int CNT_W = lane_cnt_w(NLANE),
    localparam int IDX_W = lane_idx_w(NLANE)
) (
    input  logic [NLANE-1:0] i_valid,
    input  logic [NLANE-1:0] i_excp,
    input  logic [NLANE-1:0] i_mret,
    input  logic [NLANE-1:0] i_wfi,
    input  logic [NLANE-1:0] i_bjp,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx,
    output cmt_event_e       o_ev,
    output logic [CNT_W-1:0] o_retire_cnt
);

    logic w_run;

    always_comb begin
        // NOTE: blocking assignments here let w_run and o_found carry state across loop iterations within one evaluation.
        w_run        = 1'b1;
        o_found      = 1'b0;
        o_idx        = '0;
        o_ev         = EV_NONE;
        o_retire_cnt = '0;
        for (int k = 0; k < NLANE; k++) begin
            w_run = w_run & i_valid[k];
            if (w_run && !o_found) begin
                if (i_excp[k]) begin
                    o_found      = 1'b1;
                    o_idx        = IDX_W'(k);
                    o_ev         = EV_EXCP;
                    o_retire_cnt = CNT_W'(k);
                end else if (i_mret[k] || i_wfi[k] || i_bjp[k]) begin
                    o_found      = 1'b1;
                    o_idx        = IDX_W'(k);
                    o_ev         = i_mret[k] ? EV_MRET : (i_wfi[k] ? EV_WFI : EV_BJP);
                    o_retire_cnt = CNT_W'(k + 1);
                end else begin
                    o_retire_cnt = CNT_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/cmt_ctrl_mw.sv
// Multi-lane in-order commit controller: retirement, trap/flush arbitration,
// CSR commit strobes, post-flush holdoff and the WFI halt/sleep handshake.
module cmt_ctrl_mw
    import cmt_ctrl_mw_pkg::*;
#(
    parameter  int NLANE      = 2,
    parameter  int PC_W       = 32,
    parameter  int XLEN       = 32,
    parameter  int FLUSH_GAP  = 1,
    localparam int LANE_CNT_W = lane_cnt_w(NLANE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NLANE-1:0]      cmt_i_valid,
    input  logic [NLANE*PC_W-1:0] cmt_i_pc,
    input  logic [NLANE-1:0]      cmt_i_excp,
    input  logic [NLANE*4-1:0]    cmt_i_excp_code,
    input  logic [NLANE*PC_W-1:0] cmt_i_badaddr,
    input  logic [NLANE-1:0]      cmt_i_bjp_flush,
    input  logic [NLANE*PC_W-1:0] cmt_i_bjp_pc,
    input  logic [NLANE-1:0]      cmt_i_mret,
    input  logic [NLANE-1:0]      cmt_i_wfi,
    output logic                  cmt_o_ready,
    input  logic                  status_mie_r,
    input  logic                  meie_r,
    input  logic                  msie_r,
    input  logic                  mtie_r,
    input  logic                  ext_irq_r,
    input  logic                  sft_irq_r,
    input  logic                  tmr_irq_r,
    input  logic                  dbg_mode,
    input  logic [XLEN-1:0]       csr_mtvec_r,
    input  logic [PC_W-1:0]       csr_mepc_r,
    output logic                  wfi_halt_req,
    input  logic                  wfi_halt_ack,
    output logic                  core_wfi,
    output logic [LANE_CNT_W-1:0] cmt_retire_cnt,
    output logic                  pipe_flush_req,
    output logic [PC_W-1:0]       pipe_flush_pc,
    output logic [PC_W-1:0]       cmt_epc,
    output logic                  cmt_epc_ena,
    output logic [XLEN-1:0]       cmt_cause,
    output logic                  cmt_cause_ena,
    output logic [PC_W-1:0]       cmt_badaddr,
    output logic                  cmt_badaddr_ena,
    output logic                  cmt_status_ena,
    output logic                  cmt_mret_ena
);

    localparam int IDX_W = lane_idx_w(NLANE);

    cmt_state_e             r_state;
    cmt_state_e             w_state_nxt;
    logic [2:0]             r_gap_cnt;
    logic [PC_W-1:0]        r_wake_pc;

    logic                   w_fire;
    logic                   w_ext_en, w_sft_en, w_tmr_en;
    logic                   w_wake;
    logic                   w_irq;
    logic [XLEN-1:0]        w_irq_cause;
    logic                   w_sel_found;
    logic [IDX_W-1:0]       w_sel_idx;
    cmt_event_e             w_sel_ev;
    logic [LANE_CNT_W-1:0]  w_sel_cnt;
    logic [PC_W-1:0]        w_lane_pc;
    logic [PC_W-1:0]        w_lane_pc4;
    logic                   w_trap;
    logic                   w_gap_load;
    logic                   w_wfi_enter;
    logic                   w_unused;

    assign cmt_o_ready  = (r_state == ST_RUN);
    assign wfi_halt_req = (r_state == ST_WFI_REQ) || (r_state == ST_SLEEP);
    // Decoded straight from the state so an asynchronous reset drops it at once.
    assign core_wfi     = (r_state == ST_SLEEP);

    assign w_fire   = cmt_o_ready & cmt_i_valid[0];
    assign w_ext_en = ext_irq_r & meie_r;
    assign w_sft_en = sft_irq_r & msie_r;
    assign w_tmr_en = tmr_irq_r & mtie_r;
    assign w_wake   = w_ext_en | w_sft_en | w_tmr_en;
    assign w_irq    = status_mie_r & w_wake;

    always_comb begin
        w_irq_cause           = '0;
        w_irq_cause[XLEN-1]   = 1'b1;
        w_irq_cause[3:0]      = irq_code(w_ext_en, w_sft_en);
    end

    cmt_lane_sel #(.NLANE(NLANE)) u_lane_sel (
        .i_valid      (cmt_i_valid),
        .i_excp       (cmt_i_excp),
        .i_mret       (cmt_i_mret),
        .i_wfi        (cmt_i_wfi),
        .i_bjp        (cmt_i_bjp_flush),
        .o_found      (w_sel_found),
        .o_idx        (w_sel_idx),
        .o_ev         (w_sel_ev),
        .o_retire_cnt (w_sel_cnt)
    );

    assign w_lane_pc  = cmt_i_pc[w_sel_idx*PC_W +: PC_W];
    assign w_lane_pc4 = w_lane_pc + PC_W'(4);
    assign w_unused   = ^{csr_mtvec_r[1:0], w_sel_found};

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no path infers a latch.
        w_state_nxt     = r_state;
        w_gap_load      = 1'b0;
        w_wfi_enter     = 1'b0;
        w_trap          = 1'b0;
        cmt_retire_cnt  = '0;
        pipe_flush_req  = 1'b0;
        pipe_flush_pc   = '0;
        cmt_epc         = '0;
        cmt_epc_ena     = 1'b0;
        cmt_cause       = '0;
        cmt_cause_ena   = 1'b0;
        cmt_badaddr     = '0;
        cmt_badaddr_ena = 1'b0;
        cmt_status_ena  = 1'b0;
        cmt_mret_ena    = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (w_fire) begin
                    if (w_irq) begin
                        w_trap    = 1'b1;
                        cmt_epc   = cmt_i_pc[PC_W-1:0];
                        cmt_cause = w_irq_cause;
                    end else begin
                        cmt_retire_cnt = w_sel_cnt;
                        unique case (w_sel_ev)
                            EV_EXCP: begin
                                w_trap          = 1'b1;
                                cmt_epc         = w_lane_pc;
                                cmt_cause       = XLEN'(cmt_i_excp_code[w_sel_idx*4 +: 4]);
                                cmt_badaddr     = cmt_i_badaddr[w_sel_idx*PC_W +: PC_W];
                                cmt_badaddr_ena = 1'b1;
                            end
                            EV_MRET: begin
                                cmt_mret_ena   = 1'b1;
                                pipe_flush_req = 1'b1;
                                pipe_flush_pc  = csr_mepc_r;
                            end
                            EV_WFI: begin
                                if (!dbg_mode) begin
                                    w_wfi_enter    = 1'b1;
                                    pipe_flush_req = 1'b1;
                                    pipe_flush_pc  = w_lane_pc4;
                                    w_state_nxt    = ST_WFI_REQ;
                                end
                            end
                            EV_BJP: begin
                                pipe_flush_req = 1'b1;
                                pipe_flush_pc  = cmt_i_bjp_pc[w_sel_idx*PC_W +: PC_W];
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= 3'd1) w_state_nxt = ST_RUN;
            end
            ST_WFI_REQ: begin
                if (w_wake)            w_state_nxt = ST_WAKE;
                else if (wfi_halt_ack) w_state_nxt = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (w_wake) w_state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                w_state_nxt = ST_GAP;
                w_gap_load  = 1'b1;
                if (w_irq) begin
                    w_trap    = 1'b1;
                    cmt_epc   = r_wake_pc;
                    cmt_cause = w_irq_cause;
                end else begin
                    pipe_flush_req = 1'b1;
                    pipe_flush_pc  = r_wake_pc;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (w_trap) begin
            cmt_epc_ena    = 1'b1;
            cmt_cause_ena  = 1'b1;
            cmt_status_ena = 1'b1;
            pipe_flush_req = 1'b1;
            pipe_flush_pc  = {csr_mtvec_r[PC_W-1:2], 2'b00};
        end

        if (r_state == ST_RUN && pipe_flush_req && !w_wfi_enter) begin
            w_state_nxt = ST_GAP;
            w_gap_load  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_gap_cnt <= '0;
            r_wake_pc <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gap_load)
                r_gap_cnt <= 3'(FLUSH_GAP);
            else if (r_state == ST_GAP)
                r_gap_cnt <= r_gap_cnt - 3'd1;
            if (w_wfi_enter)
                r_wake_pc <= w_lane_pc4;
        end
    end

endmodule

// File: doc/cmt_ctrl_mw.md
Name: cmt_ctrl_mw

Overview:
Parametrised multi-lane commit controller, successor to the single-issue commit stage. It accepts up to NLANE in-order instructions per cycle and retires them oldest-first, with lane 0 oldest. It arbitrates exceptions, interrupts, branch/jump flushes, MRET and WFI, and drives the CSR commit interface and the pipeline flush. It adds a post-flush holdoff and a WFI halt/sleep handshake FSM.

Parameters:
NLANE, 2, number of commit lanes (1..4)
PC_W, 32, PC / address width
XLEN, 32, CSR data width; bit XLEN-1 of cause is the interrupt flag
FLUSH_GAP, 1, cycles cmt_o_ready is held low after any flush (1..7)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cmt_i_valid  in  NLANE  per-lane instruction valid
cmt_i_pc  in  NLANE*PC_W  per-lane PC; lane k at bits [k*PC_W +: PC_W]
cmt_i_excp  in  NLANE  per-lane synchronous exception
cmt_i_excp_code  in  NLANE*4  per-lane exception code
cmt_i_badaddr  in  NLANE*PC_W  per-lane bad address / tval
cmt_i_bjp_flush  in  NLANE  per-lane branch/jump mispredict
cmt_i_bjp_pc  in  NLANE*PC_W  per-lane redirect target
cmt_i_mret  in  NLANE  per-lane MRET
cmt_i_wfi  in  NLANE  per-lane WFI
cmt_o_ready  out  1  commit accepts the lane group this cycle
status_mie_r, meie_r, msie_r, mtie_r  in  1 each  interrupt enables
ext_irq_r, sft_irq_r, tmr_irq_r  in  1 each  pending interrupts
dbg_mode  in  1  debug mode: WFI behaves as NOP
csr_mtvec_r  in  XLEN  trap vector
csr_mepc_r  in  PC_W  MRET return address
wfi_halt_req  out  1  request to halt fetch
wfi_halt_ack  in  1  halt granted
core_wfi  out  1  core sleeping
cmt_retire_cnt  out  $clog2(NLANE+1)  instructions retired this cycle
pipe_flush_req  out  1  flush pipeline
pipe_flush_pc  out  PC_W  redirect PC
cmt_epc, cmt_epc_ena  out  PC_W, 1  mepc write
cmt_cause, cmt_cause_ena  out  XLEN, 1  mcause write
cmt_badaddr, cmt_badaddr_ena  out  PC_W, 1  mtval write
cmt_status_ena  out  1  mstatus trap update
cmt_mret_ena  out  1  mstatus MRET update

Behaviour:
- Reset: state=RUN, gap counter=0, wake_pc=0. All outputs 0 except cmt_o_ready=1.
- Commit fire = cmt_o_ready & cmt_i_valid[0]. The active group is the contiguous valid run starting at lane 0; valid lanes after a hole are ignored.
- Interrupt pending = status_mie_r & ((ext_irq_r&meie_r)|(sft_irq_r&msie_r)|(tmr_irq_r&mtie_r)).
- Interrupt priority MEI(11) > MSI(3) > MTI(7). An interrupt beats every lane event: retire_cnt=0, epc=lane0 pc.
- Otherwise k = first active lane with excp|bjp|mret|wfi. Lanes below k retire. Lanes above k are killed.
- Event at lane k:
  - excp: not retired. Trap with cause=zero-extended code, badaddr=lane k badaddr, epc=lane k pc.
  - bjp: retired. Flush to lane k bjp_pc.
  - mret: retired. cmt_mret_ena=1, flush to csr_mepc_r.
  - wfi with ~dbg_mode: retired. Flush to pc+4, latch wake_pc=pc+4, go WFI_REQ.
  - wfi with dbg_mode: retired, NOP, no flush.
  - Same-lane priority: excp > mret > wfi > bjp.
- Trap: cmt_epc_ena, cmt_cause_ena, cmt_badaddr_ena (0 for interrupts) and cmt_status_ena all pulse 1 cycle. Flush to {csr_mtvec_r[PC_W-1:2],2'b00}.
- No event: all active lanes retire, no flush.
- All flush, retire and CSR outputs are combinational in the fire cycle and are 0 when not firing.
- FSM:
  - RUN: on any flush except WFI -> GAP, counter=FLUSH_GAP.
  - GAP: ready=0, decrement; at 1 -> RUN.
  - WFI_REQ: ready=0, wfi_halt_req=1. On ack -> SLEEP. A wake condition first -> WAKE.
  - SLEEP: core_wfi=1, halt_req=1. Wake condition = any (irq&enable) regardless of status_mie_r -> WAKE.
  - WAKE (1 cycle): halt_req=0. If interrupt pending, trap with epc=wake_pc. Else flush to wake_pc. Then -> GAP.
- Interrupts are not taken in GAP; they are sampled on the next fire.
- Reset asserted mid-WFI returns to RUN, and core_wfi drops asynchronously.
- PC arithmetic is modulo 2^PC_W; pc+4 wraps.

Decomposition:
- Shared package / defines: cause codes (IRQ 3/7/11), FSM state encodings, LANE_CNT_W.
- One sub-module cmt_lane_sel: combinational first-event priority finder returning k, event type and retire count.
- FSM, CSR muxing and flush mux stay in the top.

Test Plan:
- NLANE=2, both valid, no events -> retire_cnt=2, no flush, ready stays 1.
- Lane0 pc=0x100, bjp to 0x400; lane1 valid -> retire_cnt=1, flush_pc=0x400, ready=0 for 1 cycle, lane1 killed.
- Lane1 excp code 2, pc=0x204, mtvec=0x80 -> retire_cnt=1, epc=0x204, cause=2, flush_pc=0x80, badaddr_ena=1.
- tmr+ext irq pending, mie=1, lane0 pc=0x300 -> retire_cnt=0, cause=0x8000000B, epc=0x300.
- WFI at 0x500, ack after 3 cycles, tmr_irq with mie=0 -> core_wfi=1, then flush_pc=0x504, no trap. Repeat with mie=1 -> trap, epc=0x504.
- rst_n low during SLEEP -> core_wfi=0 immediately, ready=1 after release.
